// File: rtl/traffic_conflict_monitor_if.sv
// traffic_conflict_monitor_if
//   Lamp bus as seen by the conflict monitor, plus its status outputs.
//   master : the side that drives the lamps and controls (controller / bench)
//   slave  : the monitor itself
//   Signals: light_M1/M2/MT/S [2:0] (100 red, 010 yellow, 001 green),
//            flash_mode, override, clr_fault -> monitor
//            fault, fault_code[2:0], fault_head[1:0], fault_cnt[7:0], armed <- monitor
//   Optional (FAIL_FLASH_EN): safe_M1/M2/MT/S [2:0] fail-safe lamp outputs.
interface traffic_conflict_monitor_if;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic       flash_mode;
    logic       override;
    logic       clr_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_head;
    logic [7:0] fault_cnt;
    logic       armed;
`ifdef FAIL_FLASH_EN
    logic [2:0] safe_M1;
    logic [2:0] safe_M2;
    logic [2:0] safe_MT;
    logic [2:0] safe_S;

    modport master (
        output light_M1, light_M2, light_MT, light_S, flash_mode, override, clr_fault,
        input  fault, fault_code, fault_head, fault_cnt, armed,
        input  safe_M1, safe_M2, safe_MT, safe_S
    );
    modport slave (
        input  light_M1, light_M2, light_MT, light_S, flash_mode, override, clr_fault,
        output fault, fault_code, fault_head, fault_cnt, armed,
        output safe_M1, safe_M2, safe_MT, safe_S
    );
`else
    modport master (
        output light_M1, light_M2, light_MT, light_S, flash_mode, override, clr_fault,
        input  fault, fault_code, fault_head, fault_cnt, armed
    );
    modport slave (
        input  light_M1, light_M2, light_MT, light_S, flash_mode, override, clr_fault,
        output fault, fault_code, fault_head, fault_cnt, armed
    );
`endif
endinterface

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
//   Independent safety checker for the intersection lamp bus. Each head is
//   deglitched, then the stable values are checked for conflicting greens,
//   multi-lamp and dark heads, skipped yellows and short yellows. The first
//   fault is latched with a code/head index and fault entries are counted.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous reset, active-high
//     bus  - traffic_conflict_monitor_if.slave (lamp inputs, controls, status)
//   Optional feature macro FAIL_FLASH_EN: adds registered safe_* lamp outputs
//   that pass the inputs through while healthy and flash all-red on fault.
//   Head order everywhere: 0 M1, 1 M2, 2 MT, 3 S.

// Per-head lane: deglitch, one-cycle transition history, yellow timer.
module traffic_conflict_monitor_head #(
    parameter int DEGLITCH_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_i,
    input  logic       tick_i,
    output logic [2:0] stable_o,
    output logic [2:0] prev_o,
    output logic [7:0] ytimer_o
);
    localparam int CW = $clog2(DEGLITCH_CYC + 1);

    logic [2:0]    cand_q, cand_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    prev_q, prev_d;
    logic [7:0]    ytimer_q, ytimer_d;

    always_comb begin
        cand_d   = light_i;
        hold_d   = hold_q;
        stable_d = stable_q;
        prev_d   = stable_q;
        ytimer_d = ytimer_q;
        // hold_d is the number of consecutive edges (this one included)
        // that have seen the current input value.
        if (light_i != cand_q)
            hold_d = CW'(1);
        else if (hold_q != CW'(DEGLITCH_CYC))
            hold_d = hold_q + CW'(1);
        if (hold_d == CW'(DEGLITCH_CYC))
            stable_d = light_i;
        if (stable_d == 3'b010 && stable_q != 3'b010)
            ytimer_d = '0;
        else if (stable_q == 3'b010 && tick_i && ytimer_q != 8'hFF)
            ytimer_d = ytimer_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q   <= '0;
            hold_q   <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            ytimer_q <= '0;
        end else begin
            cand_q   <= cand_d;
            hold_q   <= hold_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            ytimer_q <= ytimer_d;
        end
    end

    assign stable_o = stable_q;
    assign prev_o   = prev_q;
    assign ytimer_o = ytimer_q;
endmodule

module traffic_conflict_monitor #(
    parameter int TICK_DIV         = 100_000_000,
    parameter int DEGLITCH_CYC     = 16,
    parameter int MIN_YELLOW_TICKS = 2,
    parameter int ARM_CYC          = 1024,
    parameter int FLASH_DIV        = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    traffic_conflict_monitor_if.slave bus
);
    localparam int NUM_HEADS = 4;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ARM_CYC + 1);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [1:0] {ST_ARMING, ST_MONITOR, ST_FAULT} state_t;

    logic [NUM_HEADS-1:0][2:0] light, stable, prev;
    logic [NUM_HEADS-1:0][7:0] ytimer;

    assign light = {bus.light_S, bus.light_MT, bus.light_M2, bus.light_M1};

    // Timing tick prescaler.
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    for (genvar h = 0; h < NUM_HEADS; h++) begin : g_head
        traffic_conflict_monitor_head #(.DEGLITCH_CYC(DEGLITCH_CYC)) u_head (
            .clk      (clk),
            .rst      (rst),
            .light_i  (light[h]),
            .tick_i   (tick),
            .stable_o (stable[h]),
            .prev_o   (prev[h]),
            .ytimer_o (ytimer[h])
        );
    end

    // Violation detection on stable values. A head counts as "non-red" when
    // its green or yellow lamp is lit. Transition checks see prev != stable
    // only in the cycle right after the stable register changed.
    logic [NUM_HEADS-1:0] go, multi, dark, skip_y, short_y;
    logic                 conflict, viol;
    logic [2:0]           viol_code;
    logic [1:0]           viol_head;

    always_comb begin
        go      = '0;
        multi   = '0;
        dark    = '0;
        skip_y  = '0;
        short_y = '0;
        for (int h = 0; h < NUM_HEADS; h++) begin
            go[h]      = |stable[h][1:0];
            multi[h]   = (stable[h] & (stable[h] - 3'd1)) != 3'd0;
            dark[h]    = !bus.flash_mode && stable[h] == 3'd0;
            skip_y[h]  = !bus.flash_mode && !bus.override &&
                         prev[h] == GRN && stable[h] == RED;
            short_y[h] = !bus.flash_mode && prev[h] == YEL && stable[h] == RED &&
                         ytimer[h] < 8'(MIN_YELLOW_TICKS);
        end
        conflict = !bus.flash_mode &&
                   ((go[3] && (go[0] || go[1] || go[2])) || (go[2] && go[1]));

        // Later assignments win: highest code first, heads scanned downwards,
        // so the lowest code and then lowest head index end up selected.
        viol_code = '0;
        viol_head = '0;
        for (int h = NUM_HEADS - 1; h >= 0; h--)
            if (short_y[h]) begin viol_code = 3'd5; viol_head = 2'(h); end
        for (int h = NUM_HEADS - 1; h >= 0; h--)
            if (skip_y[h]) begin viol_code = 3'd4; viol_head = 2'(h); end
        for (int h = NUM_HEADS - 1; h >= 0; h--)
            if (dark[h]) begin viol_code = 3'd3; viol_head = 2'(h); end
        for (int h = NUM_HEADS - 1; h >= 0; h--)
            if (multi[h]) begin viol_code = 3'd2; viol_head = 2'(h); end
        if (conflict) begin
            viol_code = 3'd1;
            viol_head = 2'd0;
        end
        viol = (viol_code != 3'd0);
    end

    // Arming / monitoring / fault FSM.
    state_t        state_q, state_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic          armed_q, armed_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;
    logic [1:0]    head_q, head_d;
    logic [7:0]    cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        fault_d   = fault_q;
        code_d    = code_q;
        head_d    = head_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_ARMING: begin
                arm_cnt_d = arm_cnt_q + AW'(1);
                if (arm_cnt_q == AW'(ARM_CYC - 1)) begin
                    state_d = ST_MONITOR;
                    armed_d = 1'b1;
                end
            end
            ST_MONITOR: begin
                if (viol) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = viol_code;
                    head_d  = viol_head;
                    if (cnt_q != 8'hFF)
                        cnt_d = cnt_q + 8'd1;
                end
            end
            ST_FAULT: begin
                if (bus.clr_fault) begin
                    state_d = ST_MONITOR;
                    fault_d = 1'b0;
                end
            end
            default: state_d = ST_ARMING;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            state_q   <= ST_ARMING;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= '0;
            head_q    <= '0;
            cnt_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            head_q    <= head_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.fault_head = head_q;
    assign bus.fault_cnt  = cnt_q;
    assign bus.armed      = armed_q;

`ifdef FAIL_FLASH_EN
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [FW-1:0]             fl_cnt_q, fl_cnt_d;
    logic                      phase_q, phase_d;
    logic [NUM_HEADS-1:0][2:0] safe_q, safe_d;

    always_comb begin
        fl_cnt_d = fl_cnt_q;
        phase_d  = phase_q;
        // Restart the flash with the red half on every fault entry.
        if (fault_d && !fault_q) begin
            fl_cnt_d = '0;
            phase_d  = 1'b1;
        end else if (fault_q) begin
            if (fl_cnt_q == FW'(FLASH_DIV - 1)) begin
                fl_cnt_d = '0;
                phase_d  = !phase_q;
            end else begin
                fl_cnt_d = fl_cnt_q + FW'(1);
            end
        end
        safe_d = fault_q ? {NUM_HEADS{phase_q ? RED : 3'b000}} : light;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_cnt_q <= '0;
            phase_q  <= 1'b1;
            safe_q   <= {NUM_HEADS{RED}};
        end else begin
            fl_cnt_q <= fl_cnt_d;
            phase_q  <= phase_d;
            safe_q   <= safe_d;
        end
    end

    assign bus.safe_M1 = safe_q[0];
    assign bus.safe_M2 = safe_q[1];
    assign bus.safe_MT = safe_q[2];
    assign bus.safe_S  = safe_q[3];
`endif
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with small timing parameters:
// TICK_DIV=10, DEGLITCH_CYC=4, MIN_YELLOW_TICKS=2, ARM_CYC=8, FLASH_DIV=5.
// A new input value is seen as stable at the 4th edge and a resulting fault
// latches on the 5th edge.
module tb_traffic_conflict_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;
    localparam logic [2:0] M = 3'b011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    traffic_conflict_monitor_if bus();

    traffic_conflict_monitor #(
        .TICK_DIV(10), .DEGLITCH_CYC(4), .MIN_YELLOW_TICKS(2), .ARM_CYC(8), .FLASH_DIV(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; equals the DUT prescaler phase mod 10.
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_l(input logic [2:0] m1, m2, mt, s);
        bus.light_M1 = m1;
        bus.light_M2 = m2;
        bus.light_MT = mt;
        bus.light_S  = s;
    endtask

    task automatic clear_fault();
        bus.clr_fault = 1'b1;
        step(1);
        bus.clr_fault = 1'b0;
    endtask

    task automatic chk_fault(input string tag, input logic [2:0] code, input logic [1:0] head,
                             input logic [7:0] cnt);
        chk({tag, "_fault"}, bus.fault, 1);
        chk({tag, "_code"}, bus.fault_code, code);
        chk({tag, "_head"}, bus.fault_head, head);
        chk({tag, "_cnt"}, bus.fault_cnt, cnt);
    endtask

    // Legal signal cycle {M1,M2,MT,S} and hold lengths.
    logic [11:0] leg_l [11];
    int          leg_n [11];
    logic [2:0]  fl_seq [5];

    initial begin
        leg_l = '{{G,Y,R,R}, {G,R,R,R}, {G,R,G,R}, {G,R,Y,R}, {G,R,R,R}, {Y,R,R,R},
                  {R,R,R,R}, {R,R,R,G}, {R,R,R,Y}, {R,R,R,R}, {G,G,R,R}};
        leg_n = '{30, 10, 20, 30, 10, 30, 10, 20, 30, 10, 10};
        fl_seq = '{D, Y, D, Y, R};

        // Violation (multi-lamp and conflict) present from reset into ARMING.
        set_l(G, M, R, M);
        bus.flash_mode = 1'b0;
        bus.override   = 1'b0;
        bus.clr_fault  = 1'b0;
        #22;
        chk("rst_fault", bus.fault, 0);
        chk("rst_code", bus.fault_code, 0);
        chk("rst_head", bus.fault_head, 0);
        chk("rst_cnt", bus.fault_cnt, 0);
        chk("rst_armed", bus.armed, 0);
        rst = 1'b0;

        step(4);
        chk("arming_armed", bus.armed, 0);
        set_l(G, G, R, R);
        step(10);
        chk("arming_fault", bus.fault, 0);
        chk("arming_armed_done", bus.armed, 1);

        // Legal cycle.
        for (int i = 0; i < 11; i++) begin
            set_l(leg_l[i][11:9], leg_l[i][8:6], leg_l[i][5:3], leg_l[i][2:0]);
            step(leg_n[i]);
            chk($sformatf("legal_%0d", i), bus.fault, 0);
        end
        chk("legal_cnt", bus.fault_cnt, 0);

        // Conflict S green against M1/M2 green.
        set_l(G, G, R, G);
        step(1);
`ifdef FAIL_FLASH_EN
        chk("safe_pass_S", bus.safe_S, G);
`endif
        step(3);
        chk("conflict_early", bus.fault, 0);
        step(1);
        chk_fault("conflict", 1, 0, 1);
        set_l(G, G, R, R);
        step(1);
`ifdef FAIL_FLASH_EN
        chk("flash_e1_M1", bus.safe_M1, R);
        chk("flash_e1_S", bus.safe_S, R);
`endif
        step(4);
`ifdef FAIL_FLASH_EN
        chk("flash_e5", bus.safe_MT, R);
`endif
        step(1);
`ifdef FAIL_FLASH_EN
        chk("flash_e6", bus.safe_M2, D);
`endif
        step(4);
`ifdef FAIL_FLASH_EN
        chk("flash_e10", bus.safe_S, D);
`endif
        step(1);
`ifdef FAIL_FLASH_EN
        chk("flash_e11", bus.safe_M1, R);
`endif
        chk("latched_hold", bus.fault, 1);
        chk("latched_code", bus.fault_code, 1);
        clear_fault();
        chk("clear_gone", bus.fault, 0);
        step(5);
        chk("clear_gone_later", bus.fault, 0);
        chk("clear_gone_cnt", bus.fault_cnt, 1);
`ifdef FAIL_FLASH_EN
        chk("safe_pass_M1", bus.safe_M1, G);
        chk("safe_pass_S_red", bus.safe_S, R);
`endif

        // Glitch on M2: 3 cycles ignored, 4 cycles latched.
        set_l(G, M, R, R);
        step(3);
        set_l(G, G, R, R);
        step(6);
        chk("glitch_short", bus.fault, 0);
        set_l(G, M, R, R);
        step(4);
        chk("glitch_early", bus.fault, 0);
        step(1);
        chk_fault("multi", 2, 1, 2);
        set_l(G, G, R, R);
        step(8);
        clear_fault();
        chk("multi_clear", bus.fault, 0);

        // Short yellow on MT, aligned so exactly one tick falls inside it.
        set_l(G, Y, R, R); step(30);
        set_l(G, R, R, R); step(10);
        set_l(G, R, G, R); step(10);
        for (int i = 0; i < 20 && (cyc % 10) != 0; i++) step(1);
        chk("align", cyc % 10, 0);
        set_l(G, R, Y, R);
        step(12);
        set_l(G, R, R, R);
        step(4);
        chk("short_y_early", bus.fault, 0);
        step(1);
        chk_fault("short_y", 5, 2, 3);
        step(8);
        clear_fault();
        chk("short_y_clear", bus.fault, 0);

        // Long yellow is legal.
        set_l(G, R, G, R); step(10);
        set_l(G, R, Y, R); step(30);
        set_l(G, R, R, R); step(8);
        chk("long_y", bus.fault, 0);

        // Skip yellow, then the same with override.
        set_l(G, R, G, R); step(10);
        set_l(G, R, R, R);
        step(4);
        chk("skip_y_early", bus.fault, 0);
        step(1);
        chk_fault("skip_y", 4, 2, 4);
        step(8);
        clear_fault();
        chk("skip_y_clear", bus.fault, 0);
        bus.override = 1'b1;
        set_l(G, R, G, R); step(10);
        set_l(G, R, R, R); step(8);
        chk("override", bus.fault, 0);
        bus.override = 1'b0;
        chk("override_cnt", bus.fault_cnt, 4);

        // Night flash: dark / yellow on all heads is legal.
        bus.flash_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_l(fl_seq[i], fl_seq[i], fl_seq[i], fl_seq[i]);
            step(10);
            chk($sformatf("flash_mode_%0d", i), bus.fault, 0);
        end
        bus.flash_mode = 1'b0;
        step(5);
        chk("flash_exit", bus.fault, 0);
        chk("flash_cnt", bus.fault_cnt, 4);

        // Dark head on MT.
        set_l(G, G, R, R); step(10);
        set_l(G, G, D, R);
        step(4);
        chk("dark_early", bus.fault, 0);
        step(1);
        chk_fault("dark", 3, 2, 5);
        set_l(G, G, R, R);
        step(8);
        clear_fault();

        // Priority: multi-lamp on M2 beats dark M1.
        set_l(D, M, R, R);
        step(5);
        chk_fault("prio", 2, 1, 6);
        set_l(G, G, R, R);
        step(8);
        clear_fault();
        chk("prio_clear", bus.fault, 0);

        // Clear while the conflict persists: refault and count again.
        set_l(G, G, R, G);
        step(5);
        chk_fault("held", 1, 0, 7);
        clear_fault();
        chk("held_clear", bus.fault, 0);
        step(1);
        chk_fault("refault", 1, 0, 8);

        // Asynchronous reset mid-operation.
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_fault", bus.fault, 0);
        chk("rst_mid_cnt", bus.fault_cnt, 0);
        chk("rst_mid_armed", bus.armed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
